// File: rtl/pwm_pkg.sv
// ============================================================================
// Module   : pwm_pkg
// Brief    : Shared constants, types and level helper for the PWM output stage
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package pwm_pkg;

   localparam int              PWM_CNT_W  = 8;
   localparam int              NUM_CH     = 16;
   localparam int              PERIOD_LEN = 1 << PWM_CNT_W;
   localparam logic [PWM_CNT_W-1:0] DUTY_FULL = 8'hFF;
   localparam logic [PWM_CNT_W-1:0] CNT_LAST  = PWM_CNT_W'(PERIOD_LEN - 1);

   typedef logic [PWM_CNT_W-1:0] cnt_t;
   typedef logic [NUM_CH-1:0]    ch_vec_t;

   // Full-scale duty is clamped to a solid high rather than 255/256.
   function automatic logic pwm_level(input cnt_t cnt, input cnt_t duty);
      return (duty == DUTY_FULL) || (cnt < duty);
   endfunction

endpackage : pwm_pkg

`default_nettype wire

// File: rtl/pwm_prescaler.sv
// ============================================================================
// Module   : pwm_prescaler
// Brief    : Free-running divider producing one tick every PRESCALE clocks
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module pwm_prescaler #(
   parameter int PRESCALE = 13
) (
   input  logic clk,
   input  logic rst_n,
   output logic o_tick
);

   localparam int              CNT_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [CNT_W-1:0] C_LAST = CNT_W'(PRESCALE - 1);

   logic [CNT_W-1:0] r_pre_cnt;
   logic             w_tick;

   // With PRESCALE=1 the counter sits at zero and ticks every cycle.
   assign w_tick = (r_pre_cnt == C_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pre_cnt <= '0;
      end else if (w_tick) begin
         r_pre_cnt <= '0;
      end else begin
         r_pre_cnt <= r_pre_cnt + 1'b1;
      end
   end

   assign o_tick = w_tick;

endmodule : pwm_prescaler

`default_nettype wire

// File: rtl/pwm_engine.sv
// ============================================================================
// Module   : pwm_engine
// Brief    : 16-channel output stage: off / static high / shared 8-bit PWM
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module pwm_engine
   import pwm_pkg::*;
#(
   parameter int PRESCALE = 13
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  en_reg_out_7_0,
   input  logic [7:0]  en_reg_out_15_8,
   input  logic [7:0]  en_reg_pwm_7_0,
   input  logic [7:0]  en_reg_pwm_15_8,
   input  logic [7:0]  pwm_duty_cycle,
   output logic [15:0] pwm_out,
   output logic        period_start
);

   logic    w_tick;
   logic    w_boundary;
   logic    w_level;
   cnt_t    r_pwm_cnt;
   cnt_t    r_duty_sh;
   ch_vec_t w_en_out;
   ch_vec_t w_en_pwm;
   ch_vec_t w_out_nxt;
   ch_vec_t r_pwm_out;
   logic    r_period_start;

   pwm_prescaler #(
      .PRESCALE (PRESCALE)
   ) u_prescaler (
      .clk    (clk),
      .rst_n  (rst_n),
      .o_tick (w_tick)
   );

   assign w_boundary = w_tick && (r_pwm_cnt == CNT_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pwm_cnt <= '0;
      end else if (w_tick) begin
         r_pwm_cnt <= r_pwm_cnt + 1'b1;
      end
   end

   // Duty is only sampled on the boundary so a running pulse is never cut short.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_duty_sh      <= '0;
         r_period_start <= 1'b0;
      end else begin
         r_period_start <= w_boundary;
         if (w_boundary) begin
            r_duty_sh <= pwm_duty_cycle;
         end
      end
   end

   assign w_level  = pwm_level(r_pwm_cnt, r_duty_sh);
   assign w_en_out = {en_reg_out_15_8, en_reg_out_7_0};
   assign w_en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0};

   for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      assign w_out_nxt[gi] = w_en_out[gi] & (~w_en_pwm[gi] | w_level);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pwm_out <= '0;
      end else begin
         r_pwm_out <= w_out_nxt;
      end
   end

   assign pwm_out      = r_pwm_out;
   assign period_start = r_period_start;

endmodule : pwm_engine

`default_nettype wire
